// File: rtl/ama_err_monitor_8bit.sv
// Error-statistics monitor for an 8-bit approximate adder slice.
// Each accepted sample is compared with the exact sum, and the error distance is accumulated over a programmable window.
module ama_err_monitor_8bit #(
  parameter int WINDOW = 256,
  parameter int CNT_W  = 16,
  parameter int SUM_W  = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic             Cin,
  input  logic [7:0]       S_appr,
  input  logic             Cout_appr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] ed_sum,
  output logic [8:0]       ed_max
);

  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0] ed_sum_q, ed_sum_d;
  logic [8:0]       ed_max_q, ed_max_d;

  // Stage-1 sample registers.
  logic             s1_vld_q;
  logic [7:0]       s1_a_q, s1_b_q;
  logic             s1_cin_q;
  logic [8:0]       s1_appr_q;

  logic             accept;
  logic             start_run;
  logic [8:0]       exact;
  logic [8:0]       ed;
  logic [SUM_W:0]   sum_ext;

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign in_ready  = busy && (acc_q < WIN);
  assign accept    = in_valid && in_ready;
  assign start_run = start && (state_q != RUN);

  // Stage-2 arithmetic: exact 9-bit sum and absolute error distance.
  always_comb begin
    exact   = 9'(s1_a_q) + 9'(s1_b_q) + 9'(s1_cin_q);
    ed      = (exact >= s1_appr_q) ? (exact - s1_appr_q) : (s1_appr_q - exact);
    sum_ext = {1'b0, ed_sum_q} + (SUM_W + 1)'(ed);
  end

  // NOTE: every always_comb output gets a default first, otherwise the
  // branches that leave it unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    ed_sum_d     = ed_sum_q;
    ed_max_d     = ed_max_q;

    if (s1_vld_q) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if (ed != 9'd0) err_cnt_d = err_cnt_q + CNT_W'(1);
      ed_sum_d = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
      if (ed > ed_max_q) ed_max_d = ed;
      // The last sample of the window retires on the same edge that enters DONE.
      if (acc_q == WIN) state_d = DONE;
    end

    if (accept) acc_d = acc_q + CNT_W'(1);

    if (start_run) begin
      state_d      = RUN;
      acc_d        = '0;
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      ed_sum_d     = '0;
      ed_max_d     = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      ed_sum_q     <= '0;
      ed_max_q     <= '0;
      s1_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      ed_sum_q     <= ed_sum_d;
      ed_max_q     <= ed_max_d;
      s1_vld_q     <= accept;
    end
  end

  // NOTE: the stage-1 payload has no reset; it is only consumed while
  // s1_vld_q is set, and s1_vld_q is reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a_q    <= A;
      s1_b_q    <= B;
      s1_cin_q  <= Cin;
      s1_appr_q <= {Cout_appr, S_appr};
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign ed_sum     = ed_sum_q;
  assign ed_max     = ed_max_q;

endmodule

// File: tb/tb_ama_err_monitor_8bit.sv
// Randomized self-checking bench for ama_err_monitor_8bit.
// Four instances with different WINDOW/SUM_W share stimulus; one is selected at a time and compared against a sample-list model.
module tb_ama_err_monitor_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start_v;
  logic       in_valid;
  logic [7:0] a, b;
  logic       cin;
  logic [8:0] appr;
  int         sel;

  always #5 clk = ~clk;

  logic        rdy [4];
  logic        bsy [4];
  logic        dn  [4];
  logic [15:0] sc  [4];
  logic [15:0] ec  [4];
  logic [8:0]  em  [4];
  logic [23:0] es0, es2, es3;
  logic [9:0]  es1;

  ama_err_monitor_8bit #(.WINDOW(4), .CNT_W(16), .SUM_W(24)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(in_valid), .in_ready(rdy[0]),
    .A(a), .B(b), .Cin(cin), .S_appr(appr[7:0]), .Cout_appr(appr[8]),
    .busy(bsy[0]), .done(dn[0]), .sample_cnt(sc[0]), .err_cnt(ec[0]), .ed_sum(es0), .ed_max(em[0]));

  ama_err_monitor_8bit #(.WINDOW(3), .CNT_W(16), .SUM_W(10)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(in_valid), .in_ready(rdy[1]),
    .A(a), .B(b), .Cin(cin), .S_appr(appr[7:0]), .Cout_appr(appr[8]),
    .busy(bsy[1]), .done(dn[1]), .sample_cnt(sc[1]), .err_cnt(ec[1]), .ed_sum(es1), .ed_max(em[1]));

  ama_err_monitor_8bit #(.WINDOW(2), .CNT_W(16), .SUM_W(24)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(in_valid), .in_ready(rdy[2]),
    .A(a), .B(b), .Cin(cin), .S_appr(appr[7:0]), .Cout_appr(appr[8]),
    .busy(bsy[2]), .done(dn[2]), .sample_cnt(sc[2]), .err_cnt(ec[2]), .ed_sum(es2), .ed_max(em[2]));

  ama_err_monitor_8bit #(.WINDOW(1), .CNT_W(16), .SUM_W(24)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .in_valid(in_valid), .in_ready(rdy[3]),
    .A(a), .B(b), .Cin(cin), .S_appr(appr[7:0]), .Cout_appr(appr[8]),
    .busy(bsy[3]), .done(dn[3]), .sample_cnt(sc[3]), .err_cnt(ec[3]), .ed_sum(es3), .ed_max(em[3]));

  logic        o_rdy, o_busy, o_done;
  logic [15:0] o_sc, o_ec;
  logic [31:0] o_sum;
  logic [8:0]  o_max;

  always_comb begin
    o_rdy  = 1'b0;
    o_busy = 1'b0;
    o_done = 1'b0;
    o_sc   = '0;
    o_ec   = '0;
    o_sum  = '0;
    o_max  = '0;
    if (sel >= 0 && sel < 4) begin
      o_rdy  = rdy[sel];
      o_busy = bsy[sel];
      o_done = dn[sel];
      o_sc   = sc[sel];
      o_ec   = ec[sel];
      o_max  = em[sel];
    end
    case (sel)
      0:       o_sum = 32'(es0);
      1:       o_sum = 32'(es1);
      2:       o_sum = 32'(es2);
      3:       o_sum = 32'(es3);
      default: o_sum = '0;
    endcase
  end

  function automatic int win_of(input int s);
    case (s)
      0: return 4;
      1: return 3;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int sw_of(input int s);
    return (s == 1) ? 10 : 24;
  endfunction

  function automatic int ed_of(input int xa, input int xb, input int xc, input int xappr);
    int d;
    d = (xa + xb + xc) - xappr;
    return (d < 0) ? -d : d;
  endfunction

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (sel=%0d t=%0t): got %0d, expected %0d", tag, sel, $time, obs, exp);
    end
  endtask

  // Reference model: mode 0=idle 1=run 2=done; eds holds the error distance of every retired sample.
  int m_mode, m_acc, m_pend_ed, step_no;
  bit m_pend;
  int eds[$];

  task automatic model_clear();
    m_mode = 0;
    m_acc  = 0;
    m_pend = 1'b0;
    eds.delete();
  endtask

  task automatic check_outputs(input string pfx);
    longint sum;
    int     nerr, mx, cap;
    sum = 0; nerr = 0; mx = 0;
    foreach (eds[i]) begin
      sum += eds[i];
      if (eds[i] != 0) nerr++;
      if (eds[i] > mx) mx = eds[i];
    end
    cap = (1 << sw_of(sel)) - 1;
    if (sum > cap) sum = cap;
    check({pfx, "sample_cnt"}, 32'(o_sc), eds.size());
    check({pfx, "err_cnt"}, 32'(o_ec), nerr);
    check({pfx, "ed_sum"}, o_sum, 32'(sum));
    check({pfx, "ed_max"}, 32'(o_max), mx);
    check({pfx, "busy"}, 32'(o_busy), (m_mode == 1) ? 1 : 0);
    check({pfx, "done"}, 32'(o_done), (m_mode == 2) ? 1 : 0);
  endtask

  // One clock cycle: drive at edge+1, check in_ready before the edge, check results at edge+1.
  task automatic step(input bit st, input bit v, input logic [7:0] sa, input logic [7:0] sb,
                      input bit sc_in, input logic [8:0] sappr);
    bit acc_now;
    int pre_mode;
    start_v  = st ? (4'b0001 << sel) : 4'b0000;
    in_valid = v;
    a        = sa;
    b        = sb;
    cin      = sc_in;
    appr     = sappr;
    #3;
    check("in_ready", 32'(o_rdy), (m_mode == 1 && m_acc < win_of(sel)) ? 1 : 0);
    acc_now = v && (m_mode == 1) && (m_acc < win_of(sel));
    @(posedge clk);
    #1;
    step_no++;
    pre_mode = m_mode;
    if (m_pend) begin
      eds.push_back(m_pend_ed);
      if (m_acc == win_of(sel)) m_mode = 2;
    end
    m_pend = acc_now;
    if (acc_now) begin
      m_acc++;
      m_pend_ed = ed_of(int'(sa), int'(sb), int'(sc_in), int'(sappr));
    end
    if (st && pre_mode != 1) begin
      eds.delete();
      m_acc  = 0;
      m_mode = 1;
      m_pend = 1'b0;
    end
    check_outputs("");
    start_v  = '0;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    start_v  = '0;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic rand_sample(output logic [7:0] sa, output logic [7:0] sb, output bit sc_o,
                             output logic [8:0] sappr);
    logic [8:0] ex;
    sa   = 8'($urandom);
    sb   = 8'($urandom);
    sc_o = 1'($urandom);
    ex   = 9'(sa) + 9'(sb) + 9'(sc_o);
    case ($urandom_range(0, 3))
      0:       sappr = ex;
      1:       sappr = ex ^ (9'd1 << $urandom_range(0, 8));
      2:       sappr = 9'($urandom);
      default: sappr = ex - 9'($urandom_range(0, 3));
    endcase
  endtask

  task automatic run_random(input int runs, input int gap_pct, input bit stray);
    logic [7:0] sa, sb;
    bit         sc_r;
    logic [8:0] sap;
    int         k;
    for (int r = 0; r < runs; r++) begin
      rand_sample(sa, sb, sc_r, sap);
      step(1'b1, 1'($urandom), sa, sb, sc_r, sap);
      k = 0;
      while (m_mode != 2 && k < 20 * win_of(sel) + 20) begin
        rand_sample(sa, sb, sc_r, sap);
        step(stray && ($urandom_range(0, 5) == 0), $urandom_range(0, 99) >= gap_pct, sa, sb, sc_r, sap);
        k++;
      end
      check("run_reached_done", 32'(o_done), 1);
      for (int i = 0; i < 2; i++) begin
        rand_sample(sa, sb, sc_r, sap);
        step(1'b0, 1'b1, sa, sb, sc_r, sap);
      end
    end
  endtask

  logic [7:0] d_a   [4];
  logic [7:0] d_b   [4];
  bit         d_c   [4];
  logic [8:0] d_ap  [4];

  task automatic run_directed(input bit gapped, input bit sat, input int n);
    int idx, k, first_acc, last_acc, done_at, prev_acc;
    idx = 0; k = 0; first_acc = -1; last_acc = -1; done_at = -1;
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
    while (m_mode != 2 && k < 60) begin
      prev_acc = m_acc;
      if (sat)
        step(1'b0, gapped ? (k % 3 == 0) : 1'b1, 8'hFF, 8'hFF, 1'b1, 9'h000);
      else
        step(1'b0, gapped ? (k % 3 == 0) : 1'b1, d_a[idx % 4], d_b[idx % 4], d_c[idx % 4], d_ap[idx % 4]);
      if (m_acc != prev_acc) begin
        if (first_acc < 0) first_acc = step_no;
        last_acc = step_no;
        idx++;
      end
      if (o_done && done_at < 0) done_at = step_no;
      k++;
    end
    check("accepted", idx, n);
    check("done_after_last", done_at - last_acc, 1);
    if (!gapped) check("done_after_first", done_at - first_acc, n);
  endtask

  initial begin
    logic [7:0] sa, sb;
    bit         sc_r;
    logic [8:0] sap;
    d_a  = '{8'hFF, 8'h80, 8'h12, 8'hFF};
    d_b  = '{8'h01, 8'h80, 8'h34, 8'hFF};
    d_c  = '{1'b0, 1'b1, 1'b0, 1'b1};
    d_ap = '{9'h0FF, 9'h0FF, 9'h046, 9'h000};
    sel = 0; step_no = 0;
    start_v = '0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; appr = '0;
    rst_n = 1'b1;
    #2;

    // Reset then idle with in_valid held high and no start.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      sel = s;
      step(1'b0, 1'b1, 8'hAA, 8'h55, 1'b1, 9'h1FF);
    end

    // WINDOW=4 back-to-back directed vectors.
    sel = 0;
    do_reset();
    run_directed(1'b0, 1'b0, 4);
    check("dir_sample_cnt", 32'(o_sc), 4);
    check("dir_err_cnt", 32'(o_ec), 3);
    check("dir_ed_sum", o_sum, 514);
    check("dir_ed_max", 32'(o_max), 511);

    // Same vectors gapped; restart from DONE.
    run_directed(1'b1, 1'b0, 4);
    check("gap_ed_sum", o_sum, 514);
    check("gap_err_cnt", 32'(o_ec), 3);

    // SUM_W=10 saturation with three ED=511 samples.
    sel = 1;
    do_reset();
    run_directed(1'b0, 1'b1, 3);
    check("sat_ed_sum", o_sum, 1023);
    check("sat_err_cnt", 32'(o_ec), 3);
    check("sat_ed_max", 32'(o_max), 511);

    // WINDOW=2: independent runs, stray starts during RUN, start in DONE with in_valid.
    sel = 2;
    do_reset();
    run_random(3, 30, 1'b1);
    rand_sample(sa, sb, sc_r, sap);
    step(1'b1, 1'b1, sa, sb, sc_r, sap);
    check("restart_cleared", 32'(o_sc), 0);
    check("restart_busy", 32'(o_busy), 1);
    run_random(1, 0, 1'b1);

    // WINDOW=1.
    sel = 3;
    do_reset();
    run_random(3, 20, 1'b1);

    // Asynchronous reset after two accepts, then a clean run.
    sel = 0;
    do_reset();
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
    step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 9'h000);
    step(1'b0, 1'b1, 8'hFF, 8'h01, 1'b0, 9'h0FF);
    #1;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("midrst_in_ready", 32'(o_rdy), 0);
    check_outputs("midrst_");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_random(1, 25, 1'b0);

    // Broader randomized runs.
    run_random(6, 40, 1'b1);
    sel = 1;
    do_reset();
    run_random(3, 20, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
